// File: rtl/exec_seq_pkg.sv
// Shared definitions for the instruction execution sequencer: FSM states,
// recognised opcodes and the opcode -> step-count table.
package exec_seq_pkg;

    localparam int CODE_W = 4;
    localparam int STEP_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_EXEC,
        ST_RETIRE,
        ST_HALT
    } state_t;

    localparam logic [7:0] OP_PUSH_EBP = 8'h55;
    localparam logic [7:0] OP_MOV_RM   = 8'h89;
    localparam logic [7:0] OP_MOV_IMM  = 8'hb8;
    localparam logic [7:0] OP_POP_EBP  = 8'h5d;
    localparam logic [7:0] OP_RET      = 8'hc3;
    localparam logic [7:0] OP_LOOP     = 8'he2;
    localparam logic [7:0] OP_PUSH_IMM = 8'h6a;

    // Zero marks an opcode the sequencer cannot execute.
    function automatic logic [STEP_W-1:0] step_count(input logic [7:0] op);
        case (op)
            OP_PUSH_EBP: return 2'd2;
            OP_MOV_RM:   return 2'd1;
            OP_MOV_IMM:  return 2'd1;
            OP_POP_EBP:  return 2'd2;
            OP_RET:      return 2'd2;
            OP_LOOP:     return 2'd3;
            OP_PUSH_IMM: return 2'd2;
            default:     return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/exec_seq_fields.sv
// Holds the decoder's per-step destination and ALU-source codes from accept
// until the next accept, and selects the pair belonging to the current step.
module exec_seq_fields
    import exec_seq_pkg::*;
(
    input  logic              clk2,
    input  logic              reset_n,
    input  logic              capture,
    input  logic [CODE_W-1:0] reg_load_1,
    input  logic [CODE_W-1:0] reg_load_2,
    input  logic [CODE_W-1:0] reg_load_3,
    input  logic [CODE_W-1:0] select_1,
    input  logic [CODE_W-1:0] select_2,
    input  logic [CODE_W-1:0] select_3,
    input  logic [STEP_W-1:0] step,
    output logic [CODE_W-1:0] load_sel,
    output logic [CODE_W-1:0] alu_sel
);

    logic [2:0][CODE_W-1:0] load_q;
    logic [2:0][CODE_W-1:0] sel_q;

    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            load_q <= '0;
            sel_q  <= '0;
        end else if (capture) begin
            load_q <= {reg_load_3, reg_load_2, reg_load_1};
            sel_q  <= {select_3, select_2, select_1};
        end
    end

    always_comb begin
        load_sel = '0;
        alu_sel  = '0;
        case (step)
            2'd1: begin load_sel = load_q[0]; alu_sel = sel_q[0]; end
            2'd2: begin load_sel = load_q[1]; alu_sel = sel_q[1]; end
            2'd3: begin load_sel = load_q[2]; alu_sel = sel_q[2]; end
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_seq.sv
// Execution sequencer: accepts a decoded word, latches its length, walks its
// micro-steps issuing register-write strobes, then retires by bumping eip.
module exec_seq
    import exec_seq_pkg::*;
(
    input  logic              clk2,
    input  logic              reset_n,
    input  logic              ope_valid,
    input  logic [7:0]        ope1,
    input  logic [CODE_W-1:0] reg_load_1,
    input  logic [CODE_W-1:0] reg_load_2,
    input  logic [CODE_W-1:0] reg_load_3,
    input  logic [CODE_W-1:0] select_1,
    input  logic [CODE_W-1:0] select_2,
    input  logic [CODE_W-1:0] select_3,
    input  logic [3:0]        num_of_ope,
    input  logic              stall,
    output logic              ope_ready,
    output logic [CODE_W-1:0] alu_sel,
    output logic [CODE_W-1:0] load_sel,
    output logic              load_we,
    output logic [STEP_W-1:0] step,
    output logic [3:0]        eip_inc,
    output logic              eip_inc_we,
    output logic              halt
);

    state_t            state, state_nx;
    logic [STEP_W-1:0] step_q, step_nx;
    logic [7:0]        op_q;
    logic [3:0]        len_q;
    logic              accept;
    logic [CODE_W-1:0] fld_load, fld_alu;

    assign accept = ope_valid && (state == ST_IDLE);
    assign step   = step_q;

    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            step_q <= '0;
            op_q   <= '0;
            len_q  <= '0;
        end else begin
            state  <= state_nx;
            step_q <= step_nx;
            if (accept)
                op_q <= ope1;
            if (state == ST_LEN)
                len_q <= num_of_ope;
        end
    end

    // The step count comes from the latched opcode, so it is as stable as the
    // captured step codes for the whole instruction.
    always_comb begin
        state_nx   = state;
        step_nx    = step_q;
        ope_ready  = 1'b0;
        load_we    = 1'b0;
        alu_sel    = '0;
        load_sel   = '0;
        eip_inc    = '0;
        eip_inc_we = 1'b0;
        halt       = 1'b0;
        case (state)
            ST_IDLE: begin
                ope_ready = 1'b1;
                if (ope_valid)
                    state_nx = (step_count(ope1) == 2'd0) ? ST_HALT : ST_LEN;
            end
            ST_LEN: begin
                if (num_of_ope == 4'd0) begin
                    state_nx = ST_HALT;
                end else begin
                    step_nx  = 2'd1;
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_sel  = fld_alu;
                load_sel = fld_load;
                if (!stall) begin
                    load_we = 1'b1;
                    if (step_q == step_count(op_q)) begin
                        step_nx  = 2'd0;
                        state_nx = ST_RETIRE;
                    end else begin
                        step_nx = step_q + 2'd1;
                    end
                end
            end
            ST_RETIRE: begin
                eip_inc    = len_q;
                eip_inc_we = 1'b1;
                state_nx   = ST_IDLE;
            end
            ST_HALT: begin
                halt = 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    exec_seq_fields u_fields (
        .clk2       (clk2),
        .reset_n    (reset_n),
        .capture    (accept),
        .reg_load_1 (reg_load_1),
        .reg_load_2 (reg_load_2),
        .reg_load_3 (reg_load_3),
        .select_1   (select_1),
        .select_2   (select_2),
        .select_3   (select_3),
        .step       (step_q),
        .load_sel   (fld_load),
        .alu_sel    (fld_alu)
    );

endmodule
